// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner slice.
// Holds the default parameter values, a constant log2 helper for counter sizing,
// and the per-channel state encodings (LO / PEND_HI / HI / PEND_LO) so that
// benches and debug logic can name the implicit channel states consistently.
// Optional feature macro: INPUT_COND_AUTOREPEAT_EN (auto-repeat on held inputs).
package input_conditioner_pkg;

  // Default parameter values (10 ms debounce at 50 MHz).
  localparam int DEF_NCH         = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 500000;
  localparam int DEF_REP_DELAY   = 25000000;
  localparam int DEF_REP_PERIOD  = 5000000;

  // Implicit per-channel states: dout level in bit 1, pending flag in bit 0 is
  // set when the synchronized input disagrees with dout and is being counted.
  localparam logic [1:0] ST_LO      = 2'b00;
  localparam logic [1:0] ST_PEND_HI = 2'b01;
  localparam logic [1:0] ST_HI      = 2'b10;
  localparam logic [1:0] ST_PEND_LO = 2'b11;

  // Ceiling log2 usable in constant expressions; cond_clog2(1) is 0.
  function automatic int cond_clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = value - 32'd1;
    r = 32'sd0;
    while (v > 32'd0) begin
      r = r + 32'sd1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_conditioner_chan.sv
// One conditioner channel: synchronizer chain, debounce counter, registered
// level plus one-cycle rise/fall pulses, and (with INPUT_COND_AUTOREPEAT_EN)
// an auto-repeat timer that re-fires rise while the debounced level is high.
module input_cond_chan
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
`ifdef INPUT_COND_AUTOREPEAT_EN
  ,
  parameter int REP_DELAY   = DEF_REP_DELAY,
  parameter int REP_PERIOD  = DEF_REP_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cond_clog2(DEB_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   dout_r;
  logic                   rise_r;
  logic                   fall_r;

  logic                   s_s;
  logic                   term_s;
  logic                   deb_rise_s;
  logic                   deb_fall_s;
  logic                   rise_next_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Terminal count reached while the synchronized input still disagrees with dout.
  always_comb begin
    term_s     = 1'b0;
    deb_rise_s = 1'b0;
    deb_fall_s = 1'b0;
    if ((s_s != dout_r) && (cnt_r == CNT_W'(DEB_CYCLES - 1))) begin
      term_s     = 1'b1;
      deb_rise_s = s_s;
      deb_fall_s = ~s_s;
    end else begin
      term_s     = 1'b0;
    end
  end

  // Synchronizer chain: shifts the raw pin into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce counter: any return of s to dout before terminal count clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      dout_r <= 1'b0;
    end else if (s_s == dout_r) begin
      cnt_r  <= {CNT_W{1'b0}};
    end else if (term_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      dout_r <= s_s;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(32'd1);
    end
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = cond_clog2(REP_MAX) + 1;

  logic [REP_W-1:0] rep_cnt_r;
  logic             rep_first_r;
  logic             rep_fire_s;

  // Repeat fires after REP_DELAY for the first repeat, REP_PERIOD afterwards;
  // a release on this same edge takes priority so rise and fall never coincide.
  always_comb begin
    rep_fire_s = 1'b0;
    if (dout_r && !deb_fall_s) begin
      if (rep_first_r) begin
        rep_fire_s = (rep_cnt_r == REP_W'(REP_DELAY - 1));
      end else begin
        rep_fire_s = (rep_cnt_r == REP_W'(REP_PERIOD - 1));
      end
    end else begin
      rep_fire_s = 1'b0;
    end
  end

  // Repeat timer: restarts on the debounced rise, idles while dout is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
    end else if (deb_rise_s) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b1;
    end else if (!dout_r || deb_fall_s) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
    end else if (rep_fire_s) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
    end else begin
      rep_cnt_r   <= rep_cnt_r + REP_W'(32'd1);
    end
  end

  // Rise pulse sources: debounced edge or repeat tick (mutually exclusive on dout).
  always_comb begin
    rise_next_s = deb_rise_s | rep_fire_s;
  end
`else
  // Rise pulse source: debounced edge only.
  always_comb begin
    rise_next_s = deb_rise_s;
  end
`endif

  // Edge pulses registered on the same edge that dout changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= rise_next_s;
      fall_r <= deb_fall_s;
    end
  end

  assign dout = dout_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: NCH independent synchronize/debounce/edge
// channels between board pins and game logic.
// Optional feature macro: INPUT_COND_AUTOREPEAT_EN adds auto-repeat rise pulses
// while a channel is held high; the port list is the same in both builds.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
`ifdef INPUT_COND_AUTOREPEAT_EN
  ,
  parameter int REP_DELAY   = DEF_REP_DELAY,
  parameter int REP_PERIOD  = DEF_REP_PERIOD
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] din,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    input_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
`ifdef INPUT_COND_AUTOREPEAT_EN
      ,
      .REP_DELAY   (REP_DELAY),
      .REP_PERIOD  (REP_PERIOD)
`endif
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .din  (din[g]),
      .dout (dout[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

endmodule
